// File: rtl/portrait_loader.sv
// portrait_loader: streams 80x80 palette bytes into the portrait sprite RAM.
// Optional trailer checksum: define PORTRAIT_LOADER_CHECKSUM_EN.
//
// Ports:
//   Clk, Reset_n          clock, async active-low reset
//   start, abort          session control (start sampled in IDLE only)
//   in_data/valid/ready   byte source handshake
//   wr_en/addr/data       RAM write port, one cycle after each handshake
//   busy, done, loaded    session status; loaded is sticky until next start
//   checksum_err          (checksum build only) trailer mismatch flag
module portrait_loader #(
  parameter int IMG_W  = 80,
  parameter int IMG_H  = 80,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              loaded
`ifdef PORTRAIT_LOADER_CHECKSUM_EN
  ,
  output logic              checksum_err
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FINISH
`ifdef PORTRAIT_LOADER_CHECKSUM_EN
    ,
    S_CHECK
`endif
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pix_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;

  logic hs;
  logic start_go;
  logic abort_go;
  logic load_hs;
  logic last_px;

  assign hs       = in_valid & in_ready;
  assign start_go = (state_q == S_IDLE) & start;
  assign load_hs  = (state_q == S_LOAD) & hs;
  assign last_px  = load_hs & (x_q == X_LAST) & (y_q == Y_LAST);

`ifdef PORTRAIT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              chk_hs;

  assign chk_hs   = (state_q == S_CHECK) & hs;
  assign abort_go = ((state_q == S_LOAD) | (state_q == S_CHECK)) & abort;
`else
  assign abort_go = (state_q == S_LOAD) & abort;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_px) begin
`ifdef PORTRAIT_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_FINISH;
`endif
        end
      end
`ifdef PORTRAIT_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (hs) begin
          state_d = (in_data == sum_q) ? S_FINISH : S_IDLE;
        end
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // abort masks in_ready so an aborted cycle never consumes a byte
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready = ~abort;
        busy     = 1'b1;
      end
`ifdef PORTRAIT_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = ~abort;
        busy     = 1'b1;
      end
`endif
      S_FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      loaded  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start_go | abort_go) begin
        pix_q <= '0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (load_hs) begin
        wr_en   <= 1'b1;
        wr_addr <= pix_q;
        wr_data <= in_data;
        pix_q   <= pix_q + 1'b1;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
      if (start_go) begin
        loaded <= 1'b0;
      end else if (state_q == S_FINISH) begin
        loaded <= 1'b1;
      end
    end
  end

`ifdef PORTRAIT_LOADER_CHECKSUM_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sum_q        <= '0;
      checksum_err <= 1'b0;
    end else begin
      if (start_go) begin
        sum_q        <= '0;
        checksum_err <= 1'b0;
      end else if (load_hs) begin
        sum_q <= sum_q + in_data;
      end else if (chk_hs && (in_data != sum_q)) begin
        checksum_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/portrait_loader.md
Name: portrait_loader

Overview:
- Writer side of the portrait sprite memory.
- Accepts a byte stream of 8-bit palette indices over a valid/ready handshake during a load session.
- Emits one write per pixel, in raster order, into an 80x80 on-chip sprite RAM. The draw-side reader fetches from that RAM with 2x upscaling.
- Signals busy, completion and a sticky loaded flag, so the draw logic only enables the portrait after a full image has landed.

Parameters:
- IMG_W, 80, sprite width in stored pixels
- IMG_H, 80, sprite height in stored pixels
- DATA_W, 8, pixel width (palette index bits)
- ADDR_W, 13, write address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H (6400)

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a load session; sampled in IDLE only
- abort  in  1  cancel the current session
- in_data  in  DATA_W  pixel byte from source
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts in_data this cycle
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  DATA_W  RAM write data
- busy  out  1  session in progress
- done  out  1  one-cycle pulse when a session completes successfully
- loaded  out  1  sticky: RAM holds a complete image

Behaviour:
- Reset (Reset_n=0, async):
  - State IDLE; pixel counter, x and y counters = 0.
  - All outputs 0: in_ready, wr_en, wr_addr, wr_data, busy, done, loaded.
- States: IDLE, LOAD, FINISH (plus CHECK with the optional feature).
- IDLE:
  - start=1 -> LOAD; counters cleared; loaded cleared the same edge.
  - abort is ignored in IDLE.
- LOAD:
  - in_ready = 1 combinationally, except when abort=1 in the same cycle.
  - busy=1.
  - A handshake occurs when in_valid & in_ready at a rising edge.
  - On a handshake, the next cycle presents wr_en=1, wr_addr = current pixel counter, wr_data = in_data. Write latency is exactly 1 cycle.
  - wr_en=0 in every cycle not following a handshake. wr_addr and wr_data hold their last values.
- Counters:
  - pixel counter increments by 1 per handshake; no multiplier is used.
  - x wraps from IMG_W-1 to 0 and increments y.
  - Invariant: pixel counter == y*IMG_W + x, checked by the bench.
- End of image:
  - A handshake at x=IMG_W-1, y=IMG_H-1 (pixel 6399) -> FINISH.
  - in_ready drops the following cycle; no extra byte is consumed.
- FINISH:
  - Lasts one cycle. The last write (wr_en) occurs in this cycle.
  - done=1 for this cycle; loaded set at the exit edge; -> IDLE.
  - busy=1 during FINISH; busy=0 on return to IDLE.
- abort in LOAD:
  - No handshake that cycle; -> IDLE; loaded stays 0; counters cleared.
  - A write already registered from the previous cycle still completes.
- start asserted while busy is ignored; the session is not restarted.
- Source stalls (in_valid=0) do not advance counters. Gaps of any length are legal.
- Reset mid-session: immediate return to reset values; a partial image leaves loaded=0.
- The RAM contents themselves are not cleared by the loader.

Optional Feature:
- Macro: PORTRAIT_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum_err (1 bit, reset 0) and a CHECK state.
  - An 8-bit running modular sum of all accepted pixels is kept (cleared on start).
  - After pixel 6399, -> CHECK instead of FINISH. in_ready=1 and one trailer byte is accepted without a RAM write.
  - Trailer == sum -> FINISH (done pulse, loaded=1, checksum_err=0).
  - Trailer != sum -> IDLE with checksum_err=1 held until the next start, done=0, loaded=0.
  - abort in CHECK behaves as in LOAD.
- Undefined: no checksum_err port, no CHECK state; behaviour exactly as above.

Test Plan:
- Continuous load: start, then 6400 bytes with in_valid held high, data = addr[7:0] -> 6400 writes with wr_addr 0..6399 and wr_data = wr_addr[7:0]; exactly one done pulse one cycle after the last handshake; loaded=1; no 6401st handshake.
- Backpressure/gaps: random in_valid gaps of 0-5 cycles -> write sequence identical to the continuous case; wr_en only on the cycle after each handshake; x/y wrap correct at pixels 79->80 and 6319->6320.
- Abort: abort coincident with valid at pixel 100 -> only addresses 0..99 written; the byte at 100 is not accepted; IDLE, loaded=0, done never pulses; a new start then writes from address 0.
- Restart ignored: start pulsed at pixel 3000 -> no counter reset; writes continue at 3000; session completes normally.
- Reset mid-load: Reset_n low at pixel 2000 -> all outputs 0 asynchronously (before next edge); after release, a full session completes with loaded=1.
- Checksum (macro defined): 6400 bytes of 0x01 then trailer 0x00 -> done, loaded=1. Same stream with trailer 0x01 -> checksum_err=1, loaded=0, no done.
